// File: rtl/cache_def.sv
// Shared cache/memory interface types and main-memory defaults.
package cache_def;

  localparam int MEM_LINES   = 4096;
  localparam int MEM_LATENCY = 4;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;     // 1 = write
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

endpackage

// File: rtl/main_mem_array.sv
// Backing store: one synchronous write port, one combinational read port, 128-bit lines.
module main_mem_array #(
  parameter int LINES = 4096,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [127:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [127:0]     rdata
);

  // Contents are deliberately outside reset; they rely on power-up zero.
  logic [127:0] mem [LINES];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem_ctrl.sv
// Fixed-latency main memory model: capture a request, wait LATENCY edges, pulse ready.
module main_mem_ctrl
  import cache_def::*;
#(
  parameter int LATENCY = MEM_LATENCY,
  parameter int LINES   = MEM_LINES
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic [31:0]  rd_cnt,
  output logic [31:0]  wr_cnt
);

  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t           state, state_nxt;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] cap_idx;
  logic [127:0]     cap_data;
  logic             cap_rw;
  logic             capture, enter_resp;
  logic [127:0]     rd_data;

  // Address bits outside the line index are ignored so the index wraps.
  logic unused_addr;
  assign unused_addr = ^{mem_req.addr[31:IDX_W+4], mem_req.addr[3:0]};

  // The counter is loaded with LATENCY and the last BUSY edge fires at 1,
  // so the RESPOND entry edge lands exactly LATENCY edges after capture.
  assign enter_resp = (state == BUSY) && (cnt == 8'd1);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (mem_req.valid) begin
        capture   = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == 8'd1) state_nxt = RESPOND;
      RESPOND: begin
        if (mem_req.valid) begin
          capture   = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_rw   <= 1'b0;
      mem_data <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      state          <= state_nxt;
      mem_data.ready <= enter_resp;
      if (capture) begin
        cap_idx  <= mem_req.addr[IDX_W+3:4];
        cap_data <= mem_req.data;
        cap_rw   <= mem_req.rw;
        cnt      <= 8'(LATENCY);
      end else if (state == BUSY) begin
        cnt <= cnt - 8'd1;
      end
      if (enter_resp) begin
        if (cap_rw) begin
          mem_data.data <= cap_data;
          wr_cnt        <= wr_cnt + 32'd1;
        end else begin
          mem_data.data <= rd_data;
          rd_cnt        <= rd_cnt + 32'd1;
        end
      end
    end
  end

  main_mem_array #(.LINES(LINES), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (enter_resp && cap_rw),
    .waddr (cap_idx),
    .wdata (cap_data),
    .raddr (cap_idx),
    .rdata (rd_data)
  );

endmodule
